// File: rtl/io_wr_arbiter.sv
//------------------------------------------------------------------------------
// io_wr_arbiter
// Two-requester arbiter and two-cycle write sequencer for the shared
// peripheral output bus (addr / out_data / wr_strobe).
// Optional macro IO_WR_ARB_FIXED_PRIO_EN: requester 0 wins every tie and the
// round-robin pointer is removed. Undefined (default): round-robin.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_wr_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] data0,
   output logic              ack0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data1,
   output logic              ack1,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] out_data,
   output logic              wr_strobe,
   output logic              busy,
   output logic              gnt_id
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              wr_strobe_q;
   logic              ack0_q;
   logic              ack1_q;
   logic              busy_q;
   logic              gnt_id_q;

   // Combinational arbitration results, consumed at the IDLE and STROBE edges
   logic              elig0_d;
   logic              elig1_d;
   logic              any_d;
   logic              tie_d;
   logic              win_d;
   logic [ADDR_W-1:0] win_addr_d;
   logic [DATA_W-1:0] win_data_d;

`ifdef IO_WR_ARB_FIXED_PRIO_EN
   assign tie_d = 1'b0;
`else
   // Last-winner pointer: the other requester wins the next tie
   logic last_q;
   assign tie_d = ~last_q;
`endif

   // Arbitrate, masking the just-served requester whose req is still high at the STROBE edge
   always_comb begin
      elig0_d = req0 && !((state_q == STROBE) && (gnt_id_q == 1'b0));
      elig1_d = req1 && !((state_q == STROBE) && (gnt_id_q == 1'b1));
      any_d   = elig0_d | elig1_d;
      if (elig0_d && elig1_d) begin
         win_d = tie_d;
      end else begin
         win_d = elig1_d;
      end
      win_addr_d = win_d ? addr1 : addr0;
      win_data_d = win_d ? data1 : data0;
   end

   // Write-cycle FSM; every bus output is a register written here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         wr_strobe_q <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         busy_q      <= 1'b0;
         gnt_id_q    <= 1'b0;
`ifndef IO_WR_ARB_FIXED_PRIO_EN
         last_q      <= 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (any_d) begin
                  state_q  <= SETUP;
                  addr_q   <= win_addr_d;
                  data_q   <= win_data_d;
                  gnt_id_q <= win_d;
                  busy_q   <= 1'b1;
`ifndef IO_WR_ARB_FIXED_PRIO_EN
                  last_q   <= win_d;
`endif
               end
            end
            SETUP: begin
               // Grant is never withdrawn: strobe regardless of req
               state_q     <= STROBE;
               wr_strobe_q <= 1'b1;
               ack0_q      <= ~gnt_id_q;
               ack1_q      <= gnt_id_q;
            end
            STROBE: begin
               wr_strobe_q <= 1'b0;
               ack0_q      <= 1'b0;
               ack1_q      <= 1'b0;
               if (any_d) begin
                  // Back-to-back grant to the other requester
                  state_q  <= SETUP;
                  addr_q   <= win_addr_d;
                  data_q   <= win_data_d;
                  gnt_id_q <= win_d;
                  busy_q   <= 1'b1;
`ifndef IO_WR_ARB_FIXED_PRIO_EN
                  last_q   <= win_d;
`endif
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               wr_strobe_q <= 1'b0;
               ack0_q      <= 1'b0;
               ack1_q      <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign addr      = addr_q;
   assign out_data  = data_q;
   assign wr_strobe = wr_strobe_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign busy      = busy_q;
   assign gnt_id    = gnt_id_q;

endmodule

`default_nettype wire

// File: tb/tb_io_wr_arbiter.sv
//------------------------------------------------------------------------------
// tb_io_wr_arbiter
// Cycle-vector table for io_wr_arbiter plus a write scoreboard fed from the
// table and drained by a bus monitor on every wr_strobe.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_wr_arbiter;

   logic       clk;
   logic       rst;
   logic       req0, req1;
   logic [7:0] addr0, data0, addr1, data1;
   logic       ack0, ack1, wr_strobe, busy, gnt_id;
   logic [7:0] addr, out_data;

   int total = 0;
   int bad   = 0;

   // Expected bus writes: {ack0, ack1, gnt_id, addr, data}
   logic [18:0] sb_q[$];

   io_wr_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .addr0    (addr0),
      .data0    (data0),
      .ack0     (ack0),
      .req1     (req1),
      .addr1    (addr1),
      .data1    (data1),
      .ack1     (ack1),
      .addr     (addr),
      .out_data (out_data),
      .wr_strobe(wr_strobe),
      .busy     (busy),
      .gnt_id   (gnt_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       r0;
      logic [7:0] a0;
      logic [7:0] d0;
      logic       r1;
      logic [7:0] a1;
      logic [7:0] d1;
      logic [20:0] exp;   // {ack0, ack1, wr_strobe, busy, gnt_id, addr, out_data}
   } vec_t;

   localparam int NV = 26;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic r, input logic q0, input logic [7:0] a0v, input logic [7:0] d0v,
                               input logic q1, input logic [7:0] a1v, input logic [7:0] d1v,
                               input logic ea0, input logic ea1, input logic es, input logic eb,
                               input logic eg, input logic [7:0] ea, input logic [7:0] ed);
      vec_t v;
      v.rst = r; v.r0 = q0; v.a0 = a0v; v.d0 = d0v;
      v.r1 = q1; v.a1 = a1v; v.d1 = d1v;
      v.exp = {ea0, ea1, es, eb, eg, ea, ed};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [20:0] outs();
      return {ack0, ack1, wr_strobe, busy, gnt_id, addr, out_data};
   endfunction

   // Bus monitor: one-hot acks, no consecutive strobes, each strobe matches the scoreboard
   logic prev_stb = 1'b0;
   always @(negedge clk) begin
      logic [18:0] e;
      check("ack_onehot", {31'd0, ack0 & ack1}, 32'd0);
      check("ack_eq_strobe", {31'd0, ack0 | ack1}, {31'd0, wr_strobe});
      check("strobe_gap", {31'd0, wr_strobe & prev_stb}, 32'd0);
      if (wr_strobe) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_write", {13'd0, ack0, ack1, gnt_id, addr, out_data}, {13'd0, e});
         end
      end
      prev_stb = wr_strobe;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      req0 = 1'b0; addr0 = 8'h00; data0 = 8'h00;
      req1 = 1'b0; addr1 = 8'h00; data1 = 8'h00;

      //               rst r0 a0     d0     r1 a1     d1      ak0 ak1 stb bsy gnt addr   data
      vecs[0]  = mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0,0,0,0,0, 8'h00, 8'h00);
      // Simultaneous requests after reset: req0 first, req1 back-to-back
      vecs[1]  = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,0,0,1,0, 8'h01, 8'h11);
      vecs[2]  = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  1,0,1,1,0, 8'h01, 8'h11);
      vecs[3]  = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,0,0,1,1, 8'h02, 8'h22);
      vecs[4]  = mk(0, 0, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,1,1,1,1, 8'h02, 8'h22);
      vecs[5]  = mk(0, 0, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,0,0,0,1, 8'h02, 8'h22);
      vecs[6]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0,0,0,0,1, 8'h02, 8'h22);
      // Single write; req0 kept high through the masked STROBE edge
      vecs[7]  = mk(0, 1, 8'h10, 8'hA5, 0, 8'h00, 8'h00,  0,0,0,1,0, 8'h10, 8'hA5);
      vecs[8]  = mk(0, 1, 8'h10, 8'hA5, 0, 8'h00, 8'h00,  1,0,1,1,0, 8'h10, 8'hA5);
      vecs[9]  = mk(0, 1, 8'h10, 8'hA5, 0, 8'h00, 8'h00,  0,0,0,0,0, 8'h10, 8'hA5);
      vecs[10] = mk(0, 0, 8'h10, 8'hA5, 0, 8'h00, 8'h00,  0,0,0,0,0, 8'h10, 8'hA5);
      // Tie after requester 0 was last served
`ifdef IO_WR_ARB_FIXED_PRIO_EN
      vecs[11] = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,0,0,1,0, 8'h01, 8'h11);
      vecs[12] = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  1,0,1,1,0, 8'h01, 8'h11);
      vecs[13] = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,0,0,1,1, 8'h02, 8'h22);
      vecs[14] = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,1,1,1,1, 8'h02, 8'h22);
      vecs[15] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0,0,0,0,1, 8'h02, 8'h22);
`else
      vecs[11] = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,0,0,1,1, 8'h02, 8'h22);
      vecs[12] = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,1,1,1,1, 8'h02, 8'h22);
      vecs[13] = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  0,0,0,1,0, 8'h01, 8'h11);
      vecs[14] = mk(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22,  1,0,1,1,0, 8'h01, 8'h11);
      vecs[15] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00,  0,0,0,0,0, 8'h01, 8'h11);
`endif
      // Persistent requester 1: SETUP, STROBE, IDLE repeating
      vecs[16] = mk(0, 0, 8'h00, 8'h00, 1, 8'h07, 8'h33,  0,0,0,1,1, 8'h07, 8'h33);
      vecs[17] = mk(0, 0, 8'h00, 8'h00, 1, 8'h07, 8'h33,  0,1,1,1,1, 8'h07, 8'h33);
      vecs[18] = mk(0, 0, 8'h00, 8'h00, 1, 8'h07, 8'h33,  0,0,0,0,1, 8'h07, 8'h33);
      vecs[19] = mk(0, 0, 8'h00, 8'h00, 1, 8'h07, 8'h33,  0,0,0,1,1, 8'h07, 8'h33);
      vecs[20] = mk(0, 0, 8'h00, 8'h00, 1, 8'h07, 8'h33,  0,1,1,1,1, 8'h07, 8'h33);
      vecs[21] = mk(0, 0, 8'h00, 8'h00, 1, 8'h07, 8'h33,  0,0,0,0,1, 8'h07, 8'h33);
      vecs[22] = mk(0, 0, 8'h00, 8'h00, 0, 8'h07, 8'h33,  0,0,0,0,1, 8'h07, 8'h33);
      // Data changed during SETUP must not reach the bus
      vecs[23] = mk(0, 1, 8'h20, 8'h55, 0, 8'h00, 8'h00,  0,0,0,1,0, 8'h20, 8'h55);
      vecs[24] = mk(0, 1, 8'h20, 8'hAA, 0, 8'h00, 8'h00,  1,0,1,1,0, 8'h20, 8'h55);
      vecs[25] = mk(0, 0, 8'h20, 8'hAA, 0, 8'h00, 8'h00,  0,0,0,0,0, 8'h20, 8'h55);

      for (int i = 0; i < NV; i++) begin
         rst = vecs[i].rst;
         req0 = vecs[i].r0; addr0 = vecs[i].a0; data0 = vecs[i].d0;
         req1 = vecs[i].r1; addr1 = vecs[i].a1; data1 = vecs[i].d1;
         if (vecs[i].exp[18]) begin
            sb_q.push_back({vecs[i].exp[20:19], vecs[i].exp[16:0]});
         end
         @(posedge clk);
         #1;
         check($sformatf("row%0d", i), {11'd0, outs()}, {11'd0, vecs[i].exp});
      end

      // Asynchronous reset during STROBE loses the write; a held req restarts cleanly
      req0 = 1'b1; addr0 = 8'h30; data0 = 8'h66;
      @(posedge clk); #1;
      check("rst_pre_setup", {11'd0, outs()}, {11'd0, 5'b00010, 8'h30, 8'h66});
      @(posedge clk); #1;
      check("rst_pre_strobe", {11'd0, outs()}, {11'd0, 5'b10110, 8'h30, 8'h66});
      #2 rst = 1'b1;
      #1;
      check("rst_async", {11'd0, outs()}, 32'd0);
      #1 rst = 1'b0;
      sb_q.push_back({2'b10, 1'b0, 8'h30, 8'h66});
      @(posedge clk); #1;
      check("rst_restart_setup", {11'd0, outs()}, {11'd0, 5'b00010, 8'h30, 8'h66});
      @(posedge clk); #1;
      check("rst_restart_strobe", {11'd0, outs()}, {11'd0, 5'b10110, 8'h30, 8'h66});
      req0 = 1'b0;
      @(posedge clk); #1;
      check("rst_restart_idle", {11'd0, outs()}, {11'd0, 5'b00000, 8'h30, 8'h66});
      @(posedge clk); #1;
      check("sb_drain", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/io_wr_arbiter.md
Name: io_wr_arbiter

Overview:
Two-requester write-bus arbiter and cycle sequencer for the shared 8-bit peripheral output bus (addr / out_data / wr_strobe) that drives the output-port peripherals. Each requester (e.g. CPU-side bridge, autonomous pattern engine) posts an address/data pair. The arbiter grants one requester and generates the standard two-cycle write cycle: address and data stable for 2 clocks, with wr_strobe high in the 2nd clock only. Round-robin fairness by default.

Parameters:
ADDR_W, 8, width of port address buses
DATA_W, 8, width of write data buses

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
req0  in  1  requester 0 write request, held high until ack0
addr0  in  ADDR_W  requester 0 port address, stable while req0 high
data0  in  DATA_W  requester 0 write data, stable while req0 high
ack0  out  1  one-cycle pulse: requester 0 write completed
req1  in  1  requester 1 write request
addr1  in  ADDR_W  requester 1 port address
data1  in  DATA_W  requester 1 write data
ack1  out  1  one-cycle pulse: requester 1 write completed
addr  out  ADDR_W  shared bus port address (registered)
out_data  out  DATA_W  shared bus write data (registered)
wr_strobe  out  1  shared bus write strobe (registered)
busy  out  1  high in SETUP and STROBE
gnt_id  out  1  index of requester owning current/last cycle

Behaviour:
- Reset (async, immediate): state=IDLE; addr=0, out_data=0, wr_strobe=0, ack0=ack1=0, busy=0, gnt_id=0; last-winner pointer=1 so requester 0 wins the first tie.
- FSM states: IDLE, SETUP, STROBE. All outputs are registered.
- IDLE: if any eligible req is high at edge k, latch winner's addr/data into addr/out_data, set gnt_id, and go to SETUP. Bus is valid in cycle k+1 with wr_strobe=0 and busy=1. With no request, stay in IDLE; addr/out_data hold their last values.
- SETUP -> STROBE unconditionally. wr_strobe=1 and ack[gnt_id]=1 during the STROBE cycle; addr/out_data unchanged.
- STROBE: wr_strobe and ack drop at the next edge. Re-arbitrate at this edge with the just-served requester masked, because its req is still legally high for this edge.
  - Other requester pending -> go to SETUP directly with its addr/data (back-to-back; one write per 2 clocks).
  - Otherwise -> IDLE.
- Round-robin: on a tie, the requester not equal to the last-winner pointer wins. The pointer updates on every grant.
- Latency from req rise (sampled at edge k, bus idle) to wr_strobe high: 2 cycles (strobe during cycle k+2). ack coincides with wr_strobe.
- Requester contract:
  - Deassert req in the cycle after ack, or keep it high to request a new write. A kept-high req is honoured only after one masked cycle, so a same-requester repeat has a 1-cycle IDLE gap.
  - addr/data changes while req is high and ungranted are allowed; the values sampled at grant are used.
  - req dropped before grant: no cycle issued.
- Grant is never withdrawn mid-cycle: SETUP->STROBE completes regardless of req changes.
- Reset asserted mid-cycle: wr_strobe and ack clear immediately, no ack is issued, and the write is lost. The requester must re-request after reset.
- Never more than one ack high per cycle. wr_strobe is never high for 2 consecutive cycles.

Optional Feature:
Macro IO_WR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins ties, and the pointer logic is removed. The STROBE-edge masking of the just-served requester is retained.
- Undefined: round-robin as above.

Test Plan:
- Single write: req0=1, addr0=8'h10, data0=8'hA5 at edge 0, nothing else -> addr=8'h10, out_data=8'hA5 from cycle 1; wr_strobe=1 and ack0=1 in cycle 2 only; busy high cycles 1-2; IDLE in cycle 3.
- Simultaneous requests after reset: req0 (8'h01/8'h11) and req1 (8'h02/8'h22) rise together, both held until ack -> req0 strobes in cycle 2, req1 strobes in cycle 4 (back-to-back, no IDLE). In the next contention, req1 wins first (round-robin). With IO_WR_ARB_FIXED_PRIO_EN, req0 wins every tie.
- Persistent single requester: req1 held high with data 8'h33 -> strobes every 3 cycles (SETUP, STROBE, IDLE). Never two acks to the same write.
- Reset mid-cycle: assert rst asynchronously during STROBE -> wr_strobe, ack and busy go 0 before the next clock; addr=0, out_data=0; after release with req0 still high, a fresh cycle starts 2 cycles later.
- Data capture: change data0 from 8'h55 to 8'hAA in the SETUP cycle -> out_data stays 8'h55 through STROBE.
